// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and default sizing.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 5;

  // 2'd3 is unused; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder cell, time-shared by the serial adder controller
// across every bit position of the operands.
module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. Feeds one operand bit pair per cycle,
// LSB first, through a single full-adder cell and assembles the WIDTH-bit
// sum, carry-out and signed overflow behind a start/busy/done handshake.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // Counter value at which the MSB pair is being added.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sumNext;

  serial_fa_cell u_fa (
    .i_a    (r_shA[0]),
    .i_b    (r_shB[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  // Shift the new sum bit in from the MSB side; written without a part
  // select so that WIDTH=1 stays legal.
  always_comb begin
    w_sumNext            = r_sum >> 1;
    w_sumNext[WIDTH-1]   = w_s;
  end

  // Controller FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shA   <= '0;
      r_shB   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shA   <= a;
            r_shB   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_sum   <= w_sumNext;
          r_shA   <= r_shA >> 1;
          r_shB   <= r_shB >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an arithmetic reference model
// checked every cycle on a WIDTH=8 instance, directed literal cases, a
// random sweep, and a separate random sweep on a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  logic reset1, start1, a1, b1, cin1;
  logic busy1, done1, sum1, cout1, ovf1;

  int checks   = 0;
  int failures = 0;
  bit w1Finished = 1'b0;

  serial_adder_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  serial_adder_ctrl #(.WIDTH(1), .CNT_W(1)) dut1 (
    .clk      (clk),
    .reset    (reset1),
    .start    (start1),
    .a        (a1),
    .b        (b1),
    .cin      (cin1),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
    .cout     (cout1),
    .overflow (ovf1)
  );

  // Free-running clock, period 10.
  initial forever #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: edges since the accepted start (-1 when idle) and the
  // arithmetic result a+b+cin captured at acceptance.
  int           phase = -1;
  logic [W-1:0] mSum  = '0;
  logic         mCout = 1'b0;
  logic         mOvf  = 1'b0;
  logic [W:0]   mFull;
  logic [W-1:0] pendSum;
  logic         pendCout;
  logic         pendOvf;

  // Advance the model on each rising edge using the pre-edge inputs.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      phase = -1;
      mSum  = '0;
      mCout = 1'b0;
      mOvf  = 1'b0;
    end else if (phase < 0) begin
      if (start) begin
        phase    = 0;
        mSum     = '0;
        mCout    = 1'b0;
        mOvf     = 1'b0;
        mFull    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        pendSum  = mFull[W-1:0];
        pendCout = mFull[W];
        pendOvf  = (a[W-1] == b[W-1]) && (mFull[W-1] != a[W-1]);
      end
    end else begin
      phase++;
      if (phase == W) begin
        mSum  = pendSum;
        mCout = pendCout;
        mOvf  = pendOvf;
      end
      if (phase == W + 1) phase = -1;
    end
  end

  // Compare the WIDTH=8 instance against the model on every falling edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkVal("model_busy", busy, phase >= 0);
      checkVal("model_done", done, phase == W);
      if (phase < 0 || phase == W) begin
        checkVal("model_sum", sum, mSum);
        checkVal("model_cout", cout, mCout);
        checkVal("model_ovf", overflow, mOvf);
      end else begin
        if (phase == 0) checkVal("model_sum_cleared", sum, 0);
        checkVal("model_cout_run", cout, 0);
        checkVal("model_ovf_run", overflow, 0);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    a     = ta;
    b     = tb;
    cin   = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkVal("busy_after_accept", busy, 1);
  endtask

  task automatic waitDone(input bit scramble, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expSum,
                             input logic expCout, input logic expOv);
    checkVal({name, "_sum"}, sum, expSum);
    checkVal({name, "_cout"}, cout, expCout);
    checkVal({name, "_ovf"}, overflow, expOv);
  endtask

  // Main directed and random sequence on the WIDTH=8 instance.
  initial begin
    int           lat;
    int           firstDone;
    int           secondDone;
    int           doneSeen;
    logic [W-1:0] ta, tb;
    logic         tc;
    logic [W:0]   full;

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("reset_busy", busy, 0);
    checkVal("reset_done", done, 0);
    checkOutput("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;

    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone(1'b0, lat);
    checkVal("latency_ff_01", lat, W);
    checkOutput("ff_01", 8'h00, 1'b1, 1'b0);

    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone(1'b0, lat);
    checkVal("latency_7f_01", lat, W);
    checkOutput("7f_01", 8'h80, 1'b0, 1'b1);

    applyStimulus(8'h80, 8'h80, 1'b0);
    waitDone(1'b0, lat);
    checkOutput("80_80", 8'h00, 1'b1, 1'b1);

    applyStimulus(8'hFF, 8'hFF, 1'b1);
    waitDone(1'b1, lat);
    checkVal("latency_scramble", lat, W);
    checkOutput("ff_ff_1_scrambled", 8'hFF, 1'b1, 1'b0);

    // Start held high: back-to-back accepts with ignored starts in between.
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    firstDone  = -1;
    secondDone = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (firstDone < 0) begin
          firstDone = i;
          checkOutput("held_first", 8'h46, 1'b0, 1'b0);
        end else begin
          secondDone = i;
          checkOutput("held_second", 8'h46, 1'b0, 1'b0);
          break;
        end
      end
    end
    start = 1'b0;
    checkVal("held_done_gap", secondDone - firstDone, W + 2);

    // Reset sampled on the 4th RUN edge discards the add.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("abort_busy", busy, 0);
    checkVal("abort_done", done, 0);
    checkOutput("abort", 8'h00, 1'b0, 1'b0);
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkVal("abort_no_done", doneSeen, 0);

    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone(1'b0, lat);
    checkVal("latency_after_abort", lat, W);
    checkOutput("after_abort", 8'h02, 1'b0, 1'b0);

    // Random sweep against plain arithmetic.
    for (int n = 0; n < 1000; n++) begin
      ta   = W'($urandom);
      tb   = W'($urandom);
      tc   = 1'($urandom);
      full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      applyStimulus(ta, tb, tc);
      waitDone(1'b0, lat);
      checkVal("rand_latency", lat, W);
      checkOutput("rand", full[W-1:0], full[W],
                  (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
    end

    for (int i = 0; i < 5000 && !w1Finished; i++) @(negedge clk);
    checkVal("w1_finished", w1Finished, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Random sweep on the WIDTH=1 instance, run alongside the main sequence.
  initial begin
    logic       ta, tb, tc;
    logic [1:0] full;
    int         lat1;

    reset1 = 1'b1;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("w1_reset_busy", busy1, 0);
    checkVal("w1_reset_sum", sum1, 0);
    reset1 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      ta   = 1'($urandom);
      tb   = 1'($urandom);
      tc   = 1'($urandom);
      full = {1'b0, ta} + {1'b0, tb} + {1'b0, tc};
      @(negedge clk);
      a1     = ta;
      b1     = tb;
      cin1   = tc;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      checkVal("w1_busy", busy1, 1);
      lat1 = -1;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (done1 === 1'b1) begin
          lat1 = i;
          break;
        end
      end
      checkVal("w1_latency", lat1, 1);
      checkVal("w1_sum", sum1, full[0]);
      checkVal("w1_cout", cout1, full[1]);
      checkVal("w1_ovf", ovf1, (ta == tb) && (full[0] != ta));
      @(negedge clk);
      checkVal("w1_done_single", done1, 0);
    end
    w1Finished = 1'b1;
  end

endmodule
